// File: rtl/pulse_capture.sv
// pulse_capture
//   Front-end capture for one lighthouse photodiode envelope channel.
//   Synchronises the asynchronous envelope E, timestamps each rising edge
//   against the shared TIMESTAMP counter, measures the pulse width in CLK
//   cycles and offers one record per accepted pulse on a valid/ready port.
//
// Ports
//   CLK          fabric clock, rising-edge active
//   RESETN       asynchronous active-low reset
//   E            raw sensor envelope (asynchronous)
//   TIMESTAMP    shared free-running counter, synchronous to CLK
//   out_valid    record available
//   out_ready    downstream accepts record when out_valid && out_ready
//   out_ts       TIMESTAMP captured at the rising edge
//   out_width    pulse width in CLK cycles, saturating
//   out_sat      width counter saturated during this pulse
//   drop_count   pulses lost to output overrun, saturating at 255
//   glitch_count pulses shorter than MIN_WIDTH, saturating at 255
module pulse_capture #(
  parameter int unsigned TS_WIDTH   = 24,
  parameter int unsigned WIDTH_BITS = 16,
  parameter int unsigned MIN_WIDTH  = 4
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  E,
  input  logic [TS_WIDTH-1:0]   TIMESTAMP,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TS_WIDTH-1:0]   out_ts,
  output logic [WIDTH_BITS-1:0] out_width,
  output logic                  out_sat,
  output logic [7:0]            drop_count,
  output logic [7:0]            glitch_count
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HIGH = 1'b1;

  localparam logic [WIDTH_BITS-1:0] WMAX  = '1;
  localparam logic [WIDTH_BITS-1:0] MIN_W = WIDTH_BITS'(MIN_WIDTH);

  logic                  s1, s2, s3;
  logic [1:0]            fill;
  logic                  armed;
  logic [0:0]            state;
  logic [TS_WIDTH-1:0]   ts_start;
  logic [WIDTH_BITS-1:0] wcnt;
  logic                  sat;

  logic rise, fall;
  logic eval_pulse, accept, slot_free, load, drop, glitch;

  always_comb begin
    rise       = s2 & ~s3;
    fall       = ~s2 & s3;
    eval_pulse = (state == HIGH) && fall;
    accept     = (wcnt >= MIN_W);
    slot_free  = ~out_valid | out_ready;
    load       = eval_pulse & accept & slot_free;
    drop       = eval_pulse & accept & ~slot_free;
    glitch     = eval_pulse & ~accept;
  end

  // Synchroniser plus arming. The reset value of s2 is not a real sample of
  // E, so arming waits until s2 carries a genuine sample (fill[1]) that is
  // low; a pulse already high at reset release is thereby never reported.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      fill  <= '0;
      armed <= 1'b0;
    end else begin
      s1   <= E;
      s2   <= s1;
      s3   <= s2;
      fill <= {fill[0], 1'b1};
      if (fill[1] && !s2) armed <= 1'b1;
    end
  end

  // Edge-to-edge width measurement.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state    <= IDLE;
      ts_start <= '0;
      wcnt     <= '0;
      sat      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rise && armed) begin
            ts_start <= TIMESTAMP;
            wcnt     <= WIDTH_BITS'(1);
            sat      <= 1'b0;
            state    <= HIGH;
          end
        end
        HIGH: begin
          if (fall) begin
            state <= IDLE;
          end else if (s2) begin
            if (wcnt == WMAX) sat  <= 1'b1;
            else              wcnt <= wcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Single-entry output register; a load on the same edge as a consume keeps
  // out_valid high with the new record.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      out_valid <= 1'b0;
      out_ts    <= '0;
      out_width <= '0;
      out_sat   <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_ts    <= ts_start;
      out_width <= wcnt;
      out_sat   <= sat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      drop_count   <= '0;
      glitch_count <= '0;
    end else begin
      if (drop && drop_count != 8'hFF)     drop_count   <= drop_count + 1'b1;
      if (glitch && glitch_count != 8'hFF) glitch_count <= glitch_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pulse_capture.sv
// tb_pulse_capture
//   Directed bench for pulse_capture: a vector table of pulse widths with
//   hand-computed records, plus sequences for reset timing, overrun,
//   reset-during-pulse, timestamp wrap with same-edge consume/load, and
//   width saturation on a narrow-counter instance.
module tb_pulse_capture;

  logic        clk;
  logic        rst_n;
  logic        e;
  logic        e2;
  logic [23:0] ts;
  logic        ready;
  logic        ready2;

  logic        valid;
  logic [23:0] o_ts;
  logic [15:0] o_width;
  logic        o_sat;
  logic [7:0]  drops;
  logic [7:0]  glitches;

  logic        valid2;
  logic [23:0] o_ts2;
  logic [3:0]  o_width2;
  logic        o_sat2;
  logic [7:0]  drops2;
  logic [7:0]  glitches2;

  int passed = 0;
  int total  = 0;

  pulse_capture #(.TS_WIDTH(24), .WIDTH_BITS(16), .MIN_WIDTH(4)) dut (
    .CLK(clk), .RESETN(rst_n), .E(e), .TIMESTAMP(ts),
    .out_valid(valid), .out_ready(ready), .out_ts(o_ts),
    .out_width(o_width), .out_sat(o_sat),
    .drop_count(drops), .glitch_count(glitches)
  );

  pulse_capture #(.TS_WIDTH(24), .WIDTH_BITS(4), .MIN_WIDTH(4)) dut_narrow (
    .CLK(clk), .RESETN(rst_n), .E(e2), .TIMESTAMP(ts),
    .out_valid(valid2), .out_ready(ready2), .out_ts(o_ts2),
    .out_width(o_width2), .out_sat(o_sat2),
    .drop_count(drops2), .glitch_count(glitches2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          hi;
    logic        exp_valid;
    logic [15:0] exp_width;
    logic [7:0]  exp_glitch;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      passed++;
  endtask

  // One clock edge; inputs set before the call are sampled at this edge and
  // the timestamp advances right after it.
  task automatic tick();
    @(posedge clk);
    #1;
    ts = ts + 24'd1;
  endtask

  // Pulse of hi sampled-high edges; returns just after edge m+1 (m = first
  // low edge) so the caller controls out_ready for the evaluation edge.
  task automatic run_pulse(input int hi, input bit sel, output logic [23:0] exp_ts);
    exp_ts = ts + 24'd2;
    if (sel) e2 = 1'b1; else e = 1'b1;
    repeat (hi) tick();
    if (sel) e2 = 1'b0; else e = 1'b0;
    tick();
    tick();
  endtask

  logic [23:0] ets, ets1, ets2;

  initial begin
    vecs[0] = '{hi: 3, exp_valid: 1'b0, exp_width: 16'd0, exp_glitch: 8'd1};
    vecs[1] = '{hi: 4, exp_valid: 1'b1, exp_width: 16'd4, exp_glitch: 8'd1};
    vecs[2] = '{hi: 1, exp_valid: 1'b0, exp_width: 16'd0, exp_glitch: 8'd2};
    vecs[3] = '{hi: 2, exp_valid: 1'b0, exp_width: 16'd0, exp_glitch: 8'd3};
    vecs[4] = '{hi: 7, exp_valid: 1'b1, exp_width: 16'd7, exp_glitch: 8'd3};
    vecs[5] = '{hi: 5, exp_valid: 1'b1, exp_width: 16'd5, exp_glitch: 8'd3};

    rst_n = 1'b0; e = 1'b0; e2 = 1'b0; ts = '0; ready = 1'b1; ready2 = 1'b1;
    tick();
    tick();
    check("reset_valid",  {31'd0, valid},   32'd0);
    check("reset_ts",     {8'd0, o_ts},     32'd0);
    check("reset_width",  {16'd0, o_width}, 32'd0);
    check("reset_sat",    {31'd0, o_sat},   32'd0);
    check("reset_drop",   {24'd0, drops},   32'd0);
    check("reset_glitch", {24'd0, glitches}, 32'd0);

    // Basic record: E high at edges 5..14, TIMESTAMP 0x100 at edge 1.
    rst_n = 1'b1;
    ts = 24'h000100;
    repeat (4) tick();
    e = 1'b1;
    repeat (10) tick();
    e = 1'b0;
    tick();
    tick();
    check("basic_latency_valid", {31'd0, valid}, 32'd0);
    tick();
    check("basic_valid", {31'd0, valid},   32'd1);
    check("basic_ts",    {8'd0, o_ts},     32'h000106);
    check("basic_width", {16'd0, o_width}, 32'd10);
    check("basic_sat",   {31'd0, o_sat},   32'd0);
    tick();
    check("basic_valid_one_cycle", {31'd0, valid}, 32'd0);

    // Table: widths around MIN_WIDTH, slot always drained.
    for (int i = 0; i < 6; i++) begin
      run_pulse(vecs[i].hi, 1'b0, ets);
      tick();
      check($sformatf("vec%0d_valid", i), {31'd0, valid}, {31'd0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_width", i), {16'd0, o_width}, {16'd0, vecs[i].exp_width});
        check($sformatf("vec%0d_ts", i),    {8'd0, o_ts},     {8'd0, ets});
        check($sformatf("vec%0d_sat", i),   {31'd0, o_sat},   32'd0);
      end
      check($sformatf("vec%0d_glitch", i), {24'd0, glitches}, {24'd0, vecs[i].exp_glitch});
      check($sformatf("vec%0d_drop", i),   {24'd0, drops},    32'd0);
      tick();
      check($sformatf("vec%0d_drained", i), {31'd0, valid}, 32'd0);
      tick();
    end

    // Overrun: three accepted pulses with the slot never drained.
    ready = 1'b0;
    run_pulse(5, 1'b0, ets1);
    tick();
    check("ovr_first_valid", {31'd0, valid},   32'd1);
    check("ovr_first_width", {16'd0, o_width}, 32'd5);
    tick();
    tick();
    run_pulse(6, 1'b0, ets);
    tick();
    check("ovr_drop1",       {24'd0, drops},   32'd1);
    check("ovr_hold_width1", {16'd0, o_width}, 32'd5);
    check("ovr_hold_ts1",    {8'd0, o_ts},     {8'd0, ets1});
    tick();
    run_pulse(8, 1'b0, ets);
    tick();
    check("ovr_drop2",       {24'd0, drops},   32'd2);
    check("ovr_hold_width2", {16'd0, o_width}, 32'd5);
    check("ovr_hold_ts2",    {8'd0, o_ts},     {8'd0, ets1});
    check("ovr_hold_valid",  {31'd0, valid},   32'd1);
    ready = 1'b1;
    tick();
    check("ovr_drained", {31'd0, valid}, 32'd0);

    // Timestamp wrap, then a new record loading on the consume edge.
    ready = 1'b0;
    ts = 24'hFFFFFC;
    run_pulse(6, 1'b0, ets);
    tick();
    check("wrap_valid", {31'd0, valid},   32'd1);
    check("wrap_ts",    {8'd0, o_ts},     32'h00FFFFFE);
    check("wrap_width", {16'd0, o_width}, 32'd6);
    tick();
    run_pulse(4, 1'b0, ets2);
    check("swap_pre_valid", {31'd0, valid},   32'd1);
    check("swap_pre_width", {16'd0, o_width}, 32'd6);
    ready = 1'b1;
    tick();
    check("swap_valid", {31'd0, valid},   32'd1);
    check("swap_width", {16'd0, o_width}, 32'd4);
    check("swap_ts",    {8'd0, o_ts},     {8'd0, ets2});
    check("swap_drop",  {24'd0, drops},   32'd2);
    tick();
    check("swap_drained", {31'd0, valid}, 32'd0);

    // Reset while E is high: the in-progress pulse must not be reported.
    e = 1'b1;
    rst_n = 1'b0;
    tick();
    check("rst2_valid",  {31'd0, valid},  32'd0);
    check("rst2_drop",   {24'd0, drops},  32'd0);
    check("rst2_glitch", {24'd0, glitches}, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (20) tick();
    e = 1'b0;
    repeat (5) tick();
    check("rst2_no_record", {31'd0, valid},    32'd0);
    check("rst2_no_glitch", {24'd0, glitches}, 32'd0);
    run_pulse(6, 1'b0, ets);
    tick();
    check("rst2_rec_valid", {31'd0, valid},   32'd1);
    check("rst2_rec_width", {16'd0, o_width}, 32'd6);
    check("rst2_rec_ts",    {8'd0, o_ts},     {8'd0, ets});
    tick();
    check("rst2_drained", {31'd0, valid}, 32'd0);

    // Width saturation on the 4-bit counter instance.
    run_pulse(30, 1'b1, ets);
    tick();
    check("sat_valid", {31'd0, valid2},   32'd1);
    check("sat_width", {28'd0, o_width2}, 32'd15);
    check("sat_flag",  {31'd0, o_sat2},   32'd1);
    check("sat_ts",    {8'd0, o_ts2},     {8'd0, ets});
    tick();
    check("sat_drained", {31'd0, valid2}, 32'd0);
    tick();
    run_pulse(5, 1'b1, ets);
    tick();
    check("nosat_valid", {31'd0, valid2},   32'd1);
    check("nosat_width", {28'd0, o_width2}, 32'd5);
    check("nosat_flag",  {31'd0, o_sat2},   32'd0);
    tick();
    check("nosat_drained", {31'd0, valid2}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pulse_capture.md
# pulse_capture

Front-end capture stage for one lighthouse photodiode envelope channel. It synchronises the asynchronous sensor envelope into the fabric clock and timestamps each pulse's rising edge against the shared free-running timestamp counter. It measures pulse width and presents one record per accepted pulse on a valid/ready interface to the downstream pulse FIFO / decoder. It is built from iCE40 logic cells: plain DFFs, carry-chain counters and LUT compares.

## Interface
- TS_WIDTH, 24, width of the shared timestamp and of out_ts
- WIDTH_BITS, 16, width of the pulse-width counter and of out_width
- MIN_WIDTH, 4, minimum accepted width in cycles; shorter pulses are discarded as glitches
- CLK  input  1  fabric clock; all state updates on rising edge
- RESETN  input  1  asynchronous, active-low reset
- E  input  1  raw sensor envelope, asynchronous to CLK
- TIMESTAMP  input  TS_WIDTH  shared free-running counter, synchronous to CLK
- out_valid  output  1  record available
- out_ready  input  1  downstream accepts record when out_valid && out_ready
- out_ts  output  TS_WIDTH  TIMESTAMP captured at the rising edge
- out_width  output  WIDTH_BITS  pulse width in CLK cycles, saturating
- out_sat  output  1  width counter saturated during this pulse
- drop_count  output  8  pulses lost to output overrun, saturating at 255
- glitch_count  output  8  pulses shorter than MIN_WIDTH, saturating at 255

## Operation
- Synchroniser: s1<=E, s2<=s1, s3<=s2. rise = s2 & ~s3, fall = ~s2 & s3.
- Reset (RESETN low, asynchronous): s1..s3=0, state IDLE, armed=0, out_valid=0, out_ts=0, out_width=0, out_sat=0, drop_count=0, glitch_count=0.
- armed is set on the first edge where s2=0 after reset. While armed=0, rise is ignored. A pulse already in progress at reset release is never reported.
- FSM:
  - IDLE: on rise && armed, set ts_start<=TIMESTAMP, wcnt<=1, sat<=0, go to HIGH.
  - HIGH: while s2=1, increment wcnt. At 2^WIDTH_BITS-1, hold wcnt and set sat=1. On fall, go to IDLE and evaluate the pulse.
- Evaluate on fall:
  - wcnt < MIN_WIDTH: discard and increment glitch_count (saturating).
  - wcnt >= MIN_WIDTH (equality accepts): load the output register if slot_free = ~out_valid | out_ready. Loading sets out_ts=ts_start, out_width=wcnt, out_sat=sat, out_valid=1.
  - Accepted but slot not free: discard the new record, increment drop_count (saturating), and leave the held record unchanged.
- out_valid clears on an edge where out_ready=1 and no new record loads. When a load and a consume happen on the same edge, out_valid stays 1 with the new record.
- Output fields hold while out_valid=1 and out_ready=0.
- TIMESTAMP wrap is not special-cased; out_ts is the raw value. The consumer computes differences modulo 2^TS_WIDTH.

## Timing
- E first sampled high at edge n (stable):
  - s2=1 after edge n+1.
  - rise is true in cycle n+1..n+2.
  - ts_start captures the TIMESTAMP present just before edge n+2.
- For a clean pulse, out_width equals the number of CLK edges at which E was sampled high.
- E first sampled low at edge m: fall is evaluated at edge m+2, and out_valid is high after edge m+2 (slot free).
- Latency from E falling to out_valid is 2 cycles.
- Minimum gap: a new rise may be detected on the edge immediately after fall; back-to-back records need the slot drained each time.
- Combinational paths: none from E or out_ready to any output. All outputs are registered.

## Test plan
- Reset release with E=0, TIMESTAMP counting from 0x000100. Drive E high for 10 cycles starting at edge 5, then low, with out_ready=1. Expect:
  - one record, out_ts = TIMESTAMP value at edge 7
  - out_width=10, out_sat=0
  - out_valid high for exactly 1 cycle
- Pulses of 3 and 4 cycles with MIN_WIDTH=4: the 3-cycle pulse increments glitch_count to 1 and produces no record. The 4-cycle pulse produces a record with out_width=4.
- Hold out_ready=0 and send 3 valid pulses. Expect:
  - first record held unchanged
  - drop_count=2
  - after out_ready=1 for one cycle, out_valid=0
- Release reset while E=1, hold it high for 20 cycles, then pulse 6 cycles. Expect:
  - no record for the first pulse
  - one record for the second, out_width=6
- WIDTH_BITS=4, pulse of 30 cycles: out_width=15, out_sat=1. Next 5-cycle pulse gives out_sat=0.
- TIMESTAMP at 0xFFFFFE at rise: out_ts=0xFFFFFE, and out_width is unaffected by the timestamp wrap. Also drive a new pulse's fall in the same cycle the held record is consumed: the new record appears with no drop and out_valid is continuous.
